// File: rtl/async_tx_feeder.sv
// async_tx_feeder: byte FIFO plus launch controller feeding a UART transmitter.
// Bytes pushed on wr_en/wr_data are queued and launched one at a time with a
// single-cycle TxD_start pulse, throttled by the transmitter's TxD_busy flag.
// Optional feature macro: TX_FEED_LEVEL_EN adds the level and almost_full outputs.
module async_tx_feeder #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic          overflow,
`ifdef TX_FEED_LEVEL_EN
    output logic [AW:0]   level,
    output logic          almost_full,
`endif
    output logic          TxD_start,
    output logic [7:0]    TxD_data,
    input  logic          TxD_busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_GUARD  = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    state;
    logic [1:0]    state_next;
    logic          push;
    logic          pop;

    assign full  = (count == COUNT_FULL);
    assign empty = (count == '0);

    // A push at full is dropped even when a pop happens in the same cycle.
    assign push = wr_en && !full;
    // Popping is tied to the IDLE launch decision; busy is only honoured here.
    assign pop  = (state == ST_IDLE) && !empty && !TxD_busy;

`ifdef TX_FEED_LEVEL_EN
    localparam logic [AW:0] COUNT_ALMOST = (AW + 1)'(DEPTH - 2);

    // count is already a register, so these are registered-state derived.
    assign level       = count;
    assign almost_full = (count >= COUNT_ALMOST);
`endif

    // Storage write; contents need no reset because the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Launch FSM state register plus the transmitter-facing start/data outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            TxD_start <= 1'b0;
            TxD_data  <= 8'h00;
        end else begin
            state     <= state_next;
            TxD_start <= pop;
            if (pop) begin
                TxD_data <= mem[rd_ptr];
            end
        end
    end

    // GUARD skips one cycle of busy because the transmitter's flag lags the launch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (pop) state_next = ST_LAUNCH;
            ST_LAUNCH: state_next = ST_GUARD;
            ST_GUARD:  state_next = ST_DRAIN;
            ST_DRAIN:  if (!TxD_busy) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_async_tx_feeder.sv
// Directed bench for async_tx_feeder with a simple transmitter busy model.
// Level/almost_full checks are compiled in when TX_FEED_LEVEL_EN is defined.
module tb_async_tx_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       TxD_start;
    logic [7:0] TxD_data;
    logic       tx_busy;
`ifdef TX_FEED_LEVEL_EN
    logic [AW:0] level;
    logic        almost_full;
`endif

    // Bench-side busy control: forced value or transmitter model.
    logic       busy_force;
    logic       model_en;
    int         busy_cnt = 0;

    int passed = 0;
    int total  = 0;

    // Monitor state.
    logic [7:0] pulses[$];
    int         cyc = 0;
    int         dbl_pulse = 0;
    int         unstable = 0;
    int         min_gap = 1000;
    int         fall_cyc = 0;
    logic       fall_valid = 1'b0;
    logic       prev_start = 1'b0;
    logic       prev_busy = 1'b0;
    logic       prev_rst = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    async_tx_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
`ifdef TX_FEED_LEVEL_EN
        .level      (level),
        .almost_full(almost_full),
`endif
        .TxD_start  (TxD_start),
        .TxD_data   (TxD_data),
        .TxD_busy   (tx_busy)
    );

    always_comb begin
        tx_busy = busy_force;
        if (model_en) tx_busy = (busy_cnt != 0);
    end

    // Transmitter model: busy for 10 cycles after each start pulse.
    always @(posedge clk) begin
        if (TxD_start) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    // Records launched bytes and timing properties; cleared by DUT reset.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            pulses.delete();
            dbl_pulse  <= 0;
            unstable   <= 0;
            min_gap    <= 1000;
            fall_valid <= 1'b0;
        end else begin
            if (TxD_start) begin
                pulses.push_back(TxD_data);
                if (prev_start) dbl_pulse <= dbl_pulse + 1;
                if (fall_valid && (cyc - fall_cyc) < min_gap) min_gap <= cyc - fall_cyc;
                fall_valid <= 1'b0;
            end
            if (prev_busy && !tx_busy) begin
                fall_cyc   <= cyc;
                fall_valid <= 1'b1;
            end
            if (prev_rst && !TxD_start && TxD_data != prev_data) unstable <= unstable + 1;
        end
        prev_start <= TxD_start;
        prev_busy  <= tx_busy;
        prev_rst   <= rst_n;
        prev_data  <= TxD_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        busy_force = 1'bx;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        for (int k = 0; k < budget && pulses.size() < n; k++) tick();
    endtask

    task automatic test_reset();
        model_en = 1'b0;
        do_reset();
        busy_force = 1'b0;
        wr_en = 1'b1; wr_data = 8'h99;
        tick();
        wr_en = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        do_reset();
        busy_force = 1'b0;
        total++;
        if (full !== 1'b0 || empty !== 1'b1 || overflow !== 1'b0) begin
            $display("FAIL reset_flags full=%b empty=%b ovf=%b required 0/1/0", full, empty, overflow);
        end else passed++;
        total++;
        if (TxD_start !== 1'b0 || TxD_data !== 8'h00) begin
            $display("FAIL reset_tx start=%b data=%h required 0/00", TxD_start, TxD_data);
        end else passed++;
    endtask

    task automatic test_latency();
        model_en = 1'b0;
        do_reset();
        busy_force = 1'b0;
        wr_en = 1'b1; wr_data = 8'h55;     // cycle 0
        tick();
        wr_en = 1'b0;                      // cycle 1
        total++;
        if (TxD_start !== 1'b0 || empty !== 1'b0) begin
            $display("FAIL lat_c1 start=%b empty=%b required 0/0", TxD_start, empty);
        end else passed++;
        tick();                            // cycle 2
        total++;
        if (TxD_start !== 1'b1 || TxD_data !== 8'h55 || empty !== 1'b1) begin
            $display("FAIL lat_c2 start=%b data=%h empty=%b required 1/55/1",
                     TxD_start, TxD_data, empty);
        end else passed++;
        for (int k = 0; k < 12; k++) tick();
        total++;
        if (pulses.size() != 1) begin
            $display("FAIL lat_single pulses=%0d required 1", pulses.size());
        end else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[3];
        exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3;
        model_en = 1'b1;
        do_reset();
        busy_force = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = exp[i];
            tick();
        end
        wr_en = 1'b0;
        wait_pulses(3, 200);
        for (int k = 0; k < 20; k++) tick();
        total++;
        if (pulses.size() != 3) begin
            $display("FAIL b2b_count pulses=%0d required 3", pulses.size());
        end else begin
            passed++;
            total++;
            if (pulses[0] !== exp[0] || pulses[1] !== exp[1] || pulses[2] !== exp[2]) begin
                $display("FAIL b2b_order got %h %h %h required a1 b2 c3",
                         pulses[0], pulses[1], pulses[2]);
            end else passed++;
        end
        total++;
        if (dbl_pulse != 0 || unstable != 0) begin
            $display("FAIL b2b_pulse dbl=%0d unstable=%0d required 0/0", dbl_pulse, unstable);
        end else passed++;
        total++;
        if (min_gap < 2 || min_gap == 1000) begin
            $display("FAIL b2b_gap min_gap=%0d required >=2", min_gap);
        end else passed++;
    endtask

    task automatic test_overflow();
        model_en = 1'b0;
        do_reset();
        busy_force = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            if (i == 14) begin
                total++;
                if (full !== 1'b0) begin
                    $display("FAIL ovf_not_full full=%b required 0", full);
                end else passed++;
            end
        end
        total++;
        if (full !== 1'b1) begin
            $display("FAIL ovf_full full=%b required 1", full);
        end else passed++;
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        total++;
        if (overflow !== 1'b1 || pulses.size() != 0) begin
            $display("FAIL ovf_flag ovf=%b pulses=%0d required 1/0", overflow, pulses.size());
        end else passed++;
        model_en = 1'b1;
        wait_pulses(16, 400);
        for (int k = 0; k < 30; k++) tick();
        total++;
        if (pulses.size() != 16) begin
            $display("FAIL ovf_drain_count pulses=%0d required 16", pulses.size());
        end else begin
            int bad = 0;
            passed++;
            for (int i = 0; i < 16; i++) if (pulses[i] !== 8'(i)) bad++;
            total++;
            if (bad != 0) begin
                $display("FAIL ovf_drain_order bad=%0d required 0", bad);
            end else passed++;
        end
        total++;
        if (overflow !== 1'b1 || empty !== 1'b1) begin
            $display("FAIL ovf_sticky ovf=%b empty=%b required 1/1", overflow, empty);
        end else passed++;
    endtask

    task automatic test_stream();
        int i = 0;
        int bad = 0;
        model_en = 1'b1;
        do_reset();
        busy_force = 1'b0;
        for (int k = 0; k < 3000 && i < 40; k++) begin
            if (!full && $urandom_range(0, 2) != 0) begin
                wr_en = 1'b1; wr_data = 8'(i); i++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        wr_en = 1'b0;
        wait_pulses(40, 1500);
        for (int k = 0; k < 20; k++) tick();
        total++;
        if (pulses.size() != 40) begin
            $display("FAIL stream_count pulses=%0d required 40", pulses.size());
        end else begin
            passed++;
            for (int j = 0; j < 40; j++) if (pulses[j] !== 8'(j)) bad++;
            total++;
            if (bad != 0) begin
                $display("FAIL stream_order bad=%0d required 0", bad);
            end else passed++;
        end
        total++;
        if (overflow !== 1'b0 || empty !== 1'b1 || dbl_pulse != 0 || min_gap < 2) begin
            $display("FAIL stream_state ovf=%b empty=%b dbl=%0d gap=%0d required 0/1/0/>=2",
                     overflow, empty, dbl_pulse, min_gap);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        model_en = 1'b1;
        do_reset();
        busy_force = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            tick();
        end
        wr_en = 1'b0;                      // cycle 5: DRAIN with busy high
        total++;
        if (tx_busy !== 1'b1 || pulses.size() != 1) begin
            $display("FAIL mid_setup busy=%b pulses=%0d required 1/1", tx_busy, pulses.size());
        end else passed++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if (empty !== 1'b1 || overflow !== 1'b0 || TxD_start !== 1'b0) begin
            $display("FAIL mid_reset empty=%b ovf=%b start=%b required 1/0/0",
                     empty, overflow, TxD_start);
        end else passed++;
        for (int k = 0; k < 30; k++) tick();
        total++;
        if (pulses.size() != 0) begin
            $display("FAIL mid_no_pulse pulses=%0d required 0", pulses.size());
        end else passed++;
        wr_en = 1'b1; wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        wait_pulses(1, 50);
        for (int k = 0; k < 20; k++) tick();
        total++;
        if (pulses.size() != 1 || pulses[0] !== 8'h3C) begin
            $display("FAIL mid_relaunch pulses=%0d first=%h required 1/3c",
                     pulses.size(), (pulses.size() > 0) ? pulses[0] : 8'h00);
        end else passed++;
    endtask

`ifdef TX_FEED_LEVEL_EN
    task automatic test_level();
        int bad = 0;
        model_en = 1'b0;
        do_reset();
        busy_force = 1'b1;
        total++;
        if (level !== '0 || almost_full !== 1'b0) begin
            $display("FAIL lvl_reset level=%0d af=%b required 0/0", level, almost_full);
        end else passed++;
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            if (level !== (AW + 1)'(i) || almost_full !== (i >= 14)) bad++;
        end
        wr_en = 1'b0;
        total++;
        if (bad != 0) begin
            $display("FAIL lvl_fill bad=%0d required 0", bad);
        end else passed++;
        model_en = 1'b1;
        for (int k = 0; k < 200 && level != 13; k++) tick();
        total++;
        if (level !== 5'd13 || almost_full !== 1'b0) begin
            $display("FAIL lvl_drain level=%0d af=%b required 13/0", level, almost_full);
        end else passed++;
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        busy_force = 1'b0;
        model_en   = 1'b0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_overflow();
        test_stream();
        test_reset_mid();
`ifdef TX_FEED_LEVEL_EN
        test_level();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/async_tx_feeder.md
Name: async_tx_feeder

Overview:
- Byte FIFO and launch controller that sits directly upstream of the UART transmitter.
- Accepts bytes from system logic on a push interface and buffers them.
- Drives the transmitter's one-cycle start pulse and latched data byte.
- Throttles launches against the transmitter's busy flag so that no byte is lost or issued twice.

Parameters:
DEPTH, 16, FIFO entries; power of two, min 2
AW, 4, log2(DEPTH); pointer index width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
wr_en  in  1  push request; sampled on rising clk
wr_data  in  8  byte to push
full  out  1  FIFO holds DEPTH bytes
empty  out  1  FIFO holds 0 bytes
overflow  out  1  sticky: a push was dropped while full
TxD_start  out  1  one-cycle launch pulse to transmitter
TxD_data  out  8  byte to transmitter; stable from launch until next launch
TxD_busy  in  1  transmitter busy flag

Behaviour:
- Reset: one clock; reset is synchronous and active-low.
- Reset takes effect on the rising clk edge while rst_n=0.
  - Values: full=0, empty=1, overflow=0, TxD_start=0, TxD_data=0x00, FSM=IDLE, pointers=0, count=0.
  - FIFO contents are discarded.
- Storage: DEPTH x 8 memory.
  - rd/wr pointers are AW bits and wrap modulo DEPTH.
  - count is AW+1 bits, range 0..DEPTH.
  - full = (count==DEPTH); empty = (count==0); both registered-state derived.
- Push: wr_en & !full writes mem[wr_ptr], increments wr_ptr and count.
  - wr_en & full drops the byte and sets overflow=1. overflow stays set until reset.
  - A push at full is dropped even if a pop occurs in the same cycle.
- Pop happens only in the IDLE launch transition. Push and pop in the same cycle leave count unchanged and both pointers advance.
- FSM:
  - IDLE: if !empty & !TxD_busy, then next edge sets TxD_data<=mem[rd_ptr], TxD_start<=1, rd_ptr++, count--, go to LAUNCH. Otherwise stay.
  - LAUNCH: TxD_start is high for this cycle only; the transmitter latches the byte at the closing edge. Next edge: TxD_start<=0, go to GUARD.
  - GUARD: TxD_busy is ignored. Unconditionally go to DRAIN. This covers the one cycle before the transmitter's busy is valid.
  - DRAIN: if !TxD_busy go to IDLE, else stay.
- Latency:
  - wr_en accepted in cycle 0 into an empty FIFO with busy=0: TxD_start is high in cycle 2.
  - Back-to-back bytes: next TxD_start is high no earlier than 2 cycles after the first cycle busy is sampled low.
- TxD_start is never high for more than 1 consecutive cycle. TxD_start is never asserted while TxD_busy=1 was sampled in IDLE.
- Reset mid-operation:
  - The FSM returns to IDLE and the queue is flushed.
  - A byte already handed to the transmitter finishes on the line. The IDLE busy check prevents a new launch until it completes.
- TxD_busy is undefined/X while rst_n=0 and must not corrupt state.

Optional Feature:
- Macro: TX_FEED_LEVEL_EN.
- Defined:
  - Adds output level [AW:0], equal to count (registered).
  - Adds output almost_full [1], which is 1 when count >= DEPTH-2.
  - Both reset to 0.
- Undefined: neither port exists. Core behaviour is identical.

Test Plan:
- Reset, busy=0, push 0x55 in cycle 0 -> TxD_start=1 only in cycle 2 with TxD_data=0x55; empty=1 from cycle 2; no further pulse.
- Push 0xA1,0xB2,0xC3 back-to-back; transmitter model raises busy for 10 cycles after each start -> three single-cycle pulses in order A1,B2,C3; each start is at least 2 cycles after busy falls; TxD_data is stable between pulses.
- busy held 1, push 17 bytes 0x00..0x0F then 0xEE -> full=1 after 16th push; 0xEE dropped; overflow=1; no TxD_start while busy=1; releasing busy drains exactly 0x00..0x0F; overflow stays 1.
- Stream 40 bytes 0x00..0x27 with random wr_en gaps and the transmitter model -> output order exact across pointer wrap; count never exceeds 16; simultaneous push/pop cycles keep count constant.
- 5 bytes queued, rst_n=0 for 1 cycle while in DRAIN with busy=1 -> empty=1, overflow=0, TxD_start=0; no pulse after busy falls until a new push 0x3C, which is then launched once.
- With TX_FEED_LEVEL_EN: busy=1, push 16 bytes -> level counts 1..16; almost_full goes 1 when level reaches 14; popping to 13 clears almost_full.
